// File: rtl/ads131_pkg.sv
// Shared definitions for the ADS131A0x-style SPI responder: command opcodes,
// register-access prefixes, status constants and FSM state encoding.
package ads131_pkg;

  localparam logic [15:0] CMD_NULL    = 16'h0000;
  localparam logic [15:0] CMD_RESET   = 16'h0011;
  localparam logic [15:0] CMD_STANDBY = 16'h0022;
  localparam logic [15:0] CMD_WAKEUP  = 16'h0033;
  localparam logic [15:0] CMD_LOCK    = 16'h0555;
  localparam logic [15:0] CMD_UNLOCK  = 16'h0655;

  localparam logic [2:0]  RREG_PREFIX = 3'b001;
  localparam logic [2:0]  WREG_PREFIX = 3'b010;

  localparam logic [15:0] NULL_STATUS = 16'h2200;

  localparam int          NUM_REGS    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DECODE = 2'd3
  } state_e;

  // Register address field shared by RREG and WREG command words.
  function automatic logic [4:0] reg_addr(input logic [15:0] word);
    return word[12:8];
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;

  always_comb begin
    sync_d[0] = pin_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ads131_spi_responder.sv
// ADS131A0x-style SPI slave (CPOL=0, CPHA=1, 16-bit words) that oversamples the
// master's pins, returns a status + channel frame and decodes the command word.
module ads131_spi_responder
  import ads131_pkg::*;
#(
  parameter int                   WORD_BITS   = 16,
  parameter int                   NUM_CH      = 4,
  parameter logic [WORD_BITS-1:0] READY_WORD  = 16'hFF04,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                        system_clock,
  input  logic                        reset_n,
  input  logic                        spi_sclk,
  input  logic                        spi_cs,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  output logic                        drdy_n,
  input  logic [NUM_CH*WORD_BITS-1:0] ch_data,
  input  logic                        sample_strobe,
  output logic                        locked,
  output logic                        standby,
  output logic                        cmd_valid,
  output logic [WORD_BITS-1:0]        cmd_word,
  output logic [7:0]                  frame_count
);

  localparam int FRAME_W = (NUM_CH + 1) * WORD_BITS;
  localparam int CH_W    = NUM_CH * WORD_BITS;
  localparam int CNT_W   = $clog2(WORD_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i   (system_clock),
    .rst_ni  (reset_n),
    .pin_i   (spi_sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i   (system_clock),
    .rst_ni  (reset_n),
    .pin_i   (spi_cs),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i   (system_clock),
    .rst_ni  (reset_n),
    .pin_i   (spi_mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] cmd_sr_q, cmd_sr_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic                 drdy_q, drdy_d;
  logic                 locked_q, locked_d;
  logic                 standby_q, standby_d;
  logic [WORD_BITS-1:0] cmd_word_q, cmd_word_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [WORD_BITS-1:0] next_status_q, next_status_d;
  logic [7:0]           regs_q [NUM_REGS];
  logic [7:0]           regs_d [NUM_REGS];

  logic [CH_W-1:0]      ch_ordered;
  logic [CH_W-1:0]      ch_payload;
  logic [4:0]           addr;

  // Channel 0 sits in the LSBs of ch_data but is transmitted first.
  always_comb begin
    ch_ordered = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ordered[(NUM_CH-1-i)*WORD_BITS +: WORD_BITS] = ch_data[i*WORD_BITS +: WORD_BITS];
    end
  end

  assign ch_payload = standby_q ? '0 : ch_ordered;
  assign addr       = reg_addr(cmd_sr_q);

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_LOAD;
      ST_LOAD:   state_d = cs_rise ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = (bit_cnt_q >= CNT_W'(WORD_BITS)) ? ST_DECODE : ST_IDLE;
        end
      end
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    cmd_sr_d      = cmd_sr_q;
    miso_d        = miso_q;
    oe_d          = ~cs_lvl;
    drdy_d        = drdy_q;
    locked_d      = locked_q;
    standby_d     = standby_q;
    cmd_word_d    = cmd_word_q;
    frame_cnt_d   = frame_cnt_q;
    next_status_d = next_status_q;
    regs_d        = regs_q;
    cmd_valid     = 1'b0;

    if (sample_strobe) drdy_d = 1'b0;

    unique case (state_q)
      ST_IDLE: miso_d = 1'b0;
      ST_LOAD: begin
        miso_d    = 1'b0;
        frame_d   = {next_status_q, ch_payload};
        bit_cnt_d = '0;
        drdy_d    = ~sample_strobe;
      end
      ST_SHIFT: begin
        // Zeros shift in behind the frame, so MISO idles low past the last word.
        if (sclk_rise) begin
          miso_d  = frame_q[FRAME_W-1];
          frame_d = frame_q << 1;
        end
        if (sclk_fall && (bit_cnt_q < CNT_W'(WORD_BITS))) begin
          cmd_sr_d  = {cmd_sr_q[WORD_BITS-2:0], mosi_lvl};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        miso_d        = 1'b0;
        cmd_valid     = 1'b1;
        cmd_word_d    = cmd_sr_q;
        frame_cnt_d   = frame_cnt_q + 8'd1;
        next_status_d = NULL_STATUS;
        if (cmd_sr_q == CMD_NULL) begin
          next_status_d = NULL_STATUS;
        end else if (cmd_sr_q == CMD_RESET) begin
          for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
          locked_d      = 1'b1;
          standby_d     = 1'b0;
          next_status_d = READY_WORD;
        end else if (cmd_sr_q == CMD_STANDBY) begin
          standby_d     = 1'b1;
          next_status_d = cmd_sr_q;
        end else if (cmd_sr_q == CMD_WAKEUP) begin
          standby_d     = 1'b0;
          next_status_d = cmd_sr_q;
        end else if (cmd_sr_q == CMD_LOCK) begin
          locked_d      = 1'b1;
          next_status_d = cmd_sr_q;
        end else if (cmd_sr_q == CMD_UNLOCK) begin
          locked_d      = 1'b0;
          next_status_d = cmd_sr_q;
        end else if (cmd_sr_q[15:13] == RREG_PREFIX) begin
          next_status_d = {RREG_PREFIX, addr, regs_q[addr]};
        end else if ((cmd_sr_q[15:13] == WREG_PREFIX) && !locked_q) begin
          regs_d[addr]  = cmd_sr_q[7:0];
          next_status_d = {RREG_PREFIX, addr, cmd_sr_q[7:0]};
        end
      end
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q       <= '0;
      bit_cnt_q     <= '0;
      cmd_sr_q      <= '0;
      miso_q        <= 1'b0;
      oe_q          <= 1'b0;
      drdy_q        <= 1'b1;
      locked_q      <= 1'b1;
      standby_q     <= 1'b0;
      cmd_word_q    <= '0;
      frame_cnt_q   <= '0;
      next_status_q <= READY_WORD;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      frame_q       <= frame_d;
      bit_cnt_q     <= bit_cnt_d;
      cmd_sr_q      <= cmd_sr_d;
      miso_q        <= miso_d;
      oe_q          <= oe_d;
      drdy_q        <= drdy_d;
      locked_q      <= locked_d;
      standby_q     <= standby_d;
      cmd_word_q    <= cmd_word_d;
      frame_cnt_q   <= frame_cnt_d;
      next_status_q <= next_status_d;
      regs_q        <= regs_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign drdy_n      = drdy_q;
  assign locked      = locked_q;
  assign standby     = standby_q;
  assign cmd_word    = cmd_word_q;
  assign frame_count = frame_cnt_q;

endmodule
